if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, 2..16.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 ReSet_n  input  1  reset, asynchronous and active-low; SHALL clear all state while low.
REQ-004 InValid  input  1  fetch side presents a fetched word this cycle.
REQ-005 InPC  input  32  address of the fetched word, driven from the PC unit.
REQ-006 InInstr  input  32  instruction word from instruction memory.
REQ-007 InReady  output  1  queue can accept a word this cycle.
REQ-008 PcStall  output  1  tells the PC unit to hold PC; SHALL equal NOT InReady.
REQ-009 OutValid  output  1  head entry valid for decode.
REQ-010 OutPC  output  32  PC of the head entry.
REQ-011 OutInstr  output  32  instruction of the head entry.
REQ-012 OutReady  input  1  decode consumes the head entry this cycle.
REQ-013 Flush  input  1  discards all queued words (taken jump or branch).
REQ-014 Count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries, each holding {PC[31:0], Instr[31:0]}, with write pointer, read pointer and Count registers.
REQ-016 InReady SHALL be 1 if and only if Count < DEPTH; it SHALL NOT depend on OutReady in the same cycle (no full-queue pass-through).
REQ-017 Push SHALL occur when InValid=1, InReady=1 and Flush=0: the entry is written at the write pointer, and the write pointer advances by 1 modulo DEPTH.
REQ-018 Pop SHALL occur when OutValid=1, OutReady=1 and Flush=0: the read pointer advances by 1 modulo DEPTH.
REQ-019 Count SHALL be +1 on push-only, -1 on pop-only, and unchanged on simultaneous push and pop or on neither.
REQ-020 OutValid SHALL be 1 if and only if Count > 0; OutPC and OutInstr SHALL come from the head entry when OutValid=1.
REQ-021 When OutValid=0, OutPC SHALL be 0x0000_0000 and OutInstr SHALL be 0x0000_0000 (NOP).
REQ-022 Latency: a word pushed into an empty queue SHALL appear on OutValid/OutPC/OutInstr in the cycle after the push edge; there SHALL be no combinational path from In* to Out*.
REQ-023 Flush=1 SHALL, at the next edge, set Count=0 and both pointers to 0, and SHALL discard any same-cycle push and pop; Flush overrides all other inputs.
REQ-024 After a flush edge, OutValid SHALL be 0 and InReady SHALL be 1 in the following cycle.
REQ-025 Pointer wrap-around SHALL be seamless; ordering SHALL remain strictly FIFO across the wrap.
REQ-026 InValid while InReady=0 SHALL be ignored with no state change; the source SHALL hold the word until it is accepted.
REQ-027 OutReady while OutValid=0 SHALL be ignored.

Reset
REQ-028 While ReSet_n=0: Count=0, pointers=0, OutValid=0, OutPC=0, OutInstr=0, InReady=1, PcStall=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately, independent of Clk.
REQ-030 Storage array contents need not be cleared; they SHALL never be visible while OutValid=0.

Verification
REQ-031 Reset release, then push PC 0x3000/0x3004/0x3008 with OutReady=0 -> Count=3, OutPC=0x3000, InReady=1.
REQ-032 Push 4 words with OutReady=0 (DEPTH=4) -> Count=4, InReady=0, PcStall=1; a 5th InValid -> no change; one pop -> InReady=1 next cycle.
REQ-033 Continuous push and pop over 10 words (PC 0x3000..0x3024) -> pointers wrap, outputs in exact order, Count constant at 1.
REQ-034 Queue holding 3 entries; Flush=1 together with InValid=1 and OutReady=1 -> next cycle Count=0, OutValid=0, OutPC=0; the new word is not stored.
REQ-035 Drive ReSet_n low between edges while Count=2 -> OutValid=0 and Count=0 immediately; first push after release appears at OutPC one cycle later.
REQ-036 Empty queue with OutReady=1 held -> no underflow; Count stays 0 and OutInstr=0.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_if
// Purpose : bundles the fetch-side, decode-side and control signals of the
//           instruction fetch queue so they travel as one port.
// Signals :
//   InValid / InPC / InInstr   fetch side presents a word (PC + instruction)
//   InReady / PcStall          queue can take a word / PC unit must hold
//   OutValid / OutPC / OutInstr head entry offered to decode
//   OutReady                   decode consumes the head entry
//   Flush                      discard every queued word
//   Count                      number of valid entries
// Modports: master = fetch/decode environment, slave = the queue itself.
// ---------------------------------------------------------------------------
interface if_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          InValid;
  logic [31:0]   InPC;
  logic [31:0]   InInstr;
  logic          InReady;
  logic          PcStall;
  logic          OutValid;
  logic [31:0]   OutPC;
  logic [31:0]   OutInstr;
  logic          OutReady;
  logic          Flush;
  logic [CW-1:0] Count;

  modport master (
    output InValid, InPC, InInstr, OutReady, Flush,
    input  InReady, PcStall, OutValid, OutPC, OutInstr, Count
  );

  modport slave (
    input  InValid, InPC, InInstr, OutReady, Flush,
    output InReady, PcStall, OutValid, OutPC, OutInstr, Count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Purpose : circular-buffer FIFO between instruction fetch and decode. Each
//           entry holds {PC, instruction}. A push enters at the write pointer,
//           decode consumes the head at the read pointer, and Flush (taken
//           branch/jump) empties the queue in one edge.
// Ports   :
//   Clk      rising-edge clock for all state
//   ReSet_n  asynchronous active-low reset, clears pointers and Count
//   bus      if_fetch_queue_if.slave handshake bundle (see interface file)
// Parameter: DEPTH - number of entries, power of two in 2..16.
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             ReSet_n,
  if_fetch_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [63:0]   mem_q [DEPTH];

  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Status depends only on registered Count, so there is no In->Out path and
  // a full queue never accepts a word even if decode pops in the same cycle.
  always_comb begin
    in_ready  = (count_q < CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = bus.InValid && in_ready  && !bus.Flush;
    pop       = out_valid   && bus.OutReady && !bus.Flush;
  end

  // Pointer and Count update. DEPTH is a power of two, so the natural
  // overflow of a PW-bit pointer is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ReSet_n) begin
    if (!ReSet_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale contents are masked by out_valid below.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.InPC, bus.InInstr};
  end

  // Empty queue presents PC 0 and a NOP rather than stale storage.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    bus.InReady  = in_ready;
    bus.PcStall  = !in_ready;
    bus.OutValid = out_valid;
    bus.OutPC    = out_valid ? head[63:32] : 32'h0;
    bus.OutInstr = out_valid ? head[31:0]  : 32'h0;
    bus.Count    = count_q;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
// Purpose : self-checking bench for if_fetch_queue (DEPTH = 4). A plain SV
//           queue of {PC, instr} words is the reference; each scenario task
//           drives the DUT, advances the reference, and compares outputs.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 67 + CW;

  logic Clk = 1'b0;
  logic ReSet_n;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] model_q[$];

  if_fetch_queue_if #(.DEPTH(DEPTH)) bus();

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk     (Clk),
    .ReSet_n (ReSet_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // Expected {OutValid, OutPC, OutInstr, Count, InReady, PcStall} from the
  // reference queue contents.
  function automatic logic [VW-1:0] exp_vec();
    int          n;
    logic [63:0] head;
    n    = model_q.size();
    head = (n > 0) ? model_q[0] : 64'h0;
    return {(n > 0) ? 1'b1 : 1'b0, head[63:32], head[31:0], CW'(n),
            (n < DEPTH) ? 1'b1 : 1'b0, (n >= DEPTH) ? 1'b1 : 1'b0};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.OutValid, bus.OutPC, bus.OutInstr, bus.Count, bus.InReady, bus.PcStall};
  endfunction

  // Advance one clock: work out what the queue rules allow with the current
  // inputs, update the reference after the edge, then settle 1 time unit.
  task automatic step(output bit accepted);
    bit          do_push, do_pop, do_flush;
    logic [63:0] word;
    do_flush = bus.Flush;
    do_push  = bus.InValid && (model_q.size() < DEPTH) && !do_flush;
    do_pop   = (model_q.size() > 0) && bus.OutReady && !do_flush;
    word     = {bus.InPC, bus.InInstr};
    accepted = do_push;
    @(posedge Clk);
    if (do_flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(word);
    end
    #1;
  endtask

  task automatic idle();
    bus.InValid  = 1'b0;
    bus.InPC     = 32'h0;
    bus.InInstr  = 32'h0;
    bus.OutReady = 1'b0;
    bus.Flush    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    ReSet_n      = 1'b0;
    bus.InValid  = 1'b1;
    bus.InPC     = 32'h0000_1234;
    bus.InInstr  = 32'hDEAD_BEEF;
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL reset_hold got=%h exp=%h", dut_vec(), exp_vec());
    end
    idle();
    ReSet_n = 1'b1;
    @(posedge Clk);
    #1;
    total++;
    if (dut_vec() !== exp_vec() || bus.InReady !== 1'b1 || bus.PcStall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    bit acc;
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.InValid = 1'b1;
      bus.InPC    = 32'h3000 + 4 * i;
      bus.InInstr = $urandom;
      step(acc);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL fill_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i == 2) begin
        total++;
        if ({bus.Count, bus.OutPC, bus.InReady} !== {CW'(3), 32'h3000, 1'b1}) begin
          bad++;
          $display("[TB] FAIL fill_three count=%0d pc=%h rdy=%b exp 3/3000/1",
                   bus.Count, bus.OutPC, bus.InReady);
        end
      end
    end
    total++;
    if ({bus.Count, bus.InReady, bus.PcStall} !== {CW'(4), 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL full count=%0d rdy=%b stall=%b exp 4/0/1",
               bus.Count, bus.InReady, bus.PcStall);
    end
    // A fifth word held on the input while full must not be taken.
    bus.InPC    = 32'h3010;
    bus.InInstr = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      step(acc);
      total++;
      if (dut_vec() !== exp_vec() || acc) begin
        bad++;
        $display("[TB] FAIL full_ignore_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    step(acc);
    bus.OutReady = 1'b0;
    total++;
    if (dut_vec() !== exp_vec() || bus.InReady !== 1'b1 || bus.OutPC !== 32'h3004) begin
      bad++;
      $display("[TB] FAIL pop_frees got=%h exp=%h", dut_vec(), exp_vec());
    end
    bus.OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL drain_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    bit acc;
    idle();
    bus.InValid = 1'b1;
    bus.InPC    = 32'h3000;
    bus.InInstr = 32'hA000_0000;
    step(acc);
    for (int i = 1; i < 10; i++) begin
      bus.InValid  = 1'b1;
      bus.OutReady = 1'b1;
      bus.InPC     = 32'h3000 + 4 * i;
      bus.InInstr  = 32'hA000_0000 + i;
      step(acc);
      total++;
      if (dut_vec() !== exp_vec() || bus.Count !== CW'(1) ||
          bus.OutPC !== 32'h3000 + 4 * i) begin
        bad++;
        $display("[TB] FAIL stream_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    bus.InValid = 1'b0;
    step(acc);
    total++;
    if (dut_vec() !== exp_vec() || bus.OutValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stream_end got=%h exp=%h", dut_vec(), exp_vec());
    end
    idle();
  endtask

  task automatic test_flush();
    bit acc;
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.InValid = 1'b1;
      bus.InPC    = 32'h4000 + 4 * i;
      bus.InInstr = $urandom;
      step(acc);
    end
    bus.Flush    = 1'b1;
    bus.InValid  = 1'b1;
    bus.OutReady = 1'b1;
    bus.InPC     = 32'h5000;
    bus.InInstr  = 32'h5555_5555;
    step(acc);
    total++;
    if (dut_vec() !== exp_vec() || bus.Count !== '0 || bus.OutValid !== 1'b0 ||
        bus.OutPC !== 32'h0 || bus.InReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush got=%h exp=%h", dut_vec(), exp_vec());
    end
    idle();
    step(acc);
    total++;
    if (dut_vec() !== exp_vec() || bus.OutValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_nostore got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    idle();
    for (int i = 0; i < 2; i++) begin
      bus.InValid = 1'b1;
      bus.InPC    = 32'h4100 + 4 * i;
      bus.InInstr = $urandom;
      step(acc);
    end
    idle();
    #3;
    ReSet_n = 1'b0;
    #1;
    model_q.delete();
    total++;
    if (dut_vec() !== exp_vec() || bus.OutValid !== 1'b0 || bus.Count !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset got=%h exp=%h", dut_vec(), exp_vec());
    end
    #2;
    ReSet_n = 1'b1;
    @(posedge Clk);
    #1;
    bus.InValid = 1'b1;
    bus.InPC    = 32'h6000;
    bus.InInstr = 32'h6666_0001;
    step(acc);
    idle();
    total++;
    if (dut_vec() !== exp_vec() || bus.OutValid !== 1'b1 || bus.OutPC !== 32'h6000) begin
      bad++;
      $display("[TB] FAIL post_reset_push got=%h exp=%h", dut_vec(), exp_vec());
    end
    bus.OutReady = 1'b1;
    step(acc);
    idle();
  endtask

  task automatic test_underflow();
    bit acc;
    idle();
    bus.OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      total++;
      if (dut_vec() !== exp_vec() || bus.Count !== '0 || bus.OutInstr !== 32'h0) begin
        bad++;
        $display("[TB] FAIL underflow_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_random();
    bit acc;
    bit hold;
    bit fl;
    hold = 1'b0;
    idle();
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        bus.InPC    = $urandom & 32'hFFFF_FFFC;
        bus.InInstr = $urandom;
      end
      bus.InValid  = ($urandom_range(0, 3) != 0);
      bus.OutReady = ($urandom_range(0, 2) != 0);
      bus.Flush    = ($urandom_range(0, 19) == 0);
      fl = bus.Flush;
      step(acc);
      hold = bus.InValid && !acc && !fl;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL random_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_underflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
